// File: rtl/mult_8bit_seq_pkg.sv
// Shared constants and FSM encoding for the sequential 8x8 multiplier.
// Encoding is fixed; the unused code 2'd3 is treated as IDLE by the controller.
package mult_8bit_seq_pkg;

  localparam int NUM_ITER = 8;
  localparam logic [2:0] CNT_LAST = 3'(NUM_ITER - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder_8bit.sv
// Combinational 8-bit adder with carry in/out; feeds one partial-product add per clock.
// Zero latency; no flow control.
module adder_8bit (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  output logic [7:0] Sum,
  output logic       Cout
);

  assign {Cout, Sum} = {1'b0, A} + {1'b0, B} + {8'd0, Cin};

endmodule

// File: rtl/mult_8bit_seq.sv
// Sequential 8x8 unsigned shift-and-add multiplier: one add per clock, 8 cycles start->done.
// start is accepted only in IDLE/DONE; start during RUN is dropped (no queueing).
module mult_8bit_seq
  import mult_8bit_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic        busy,
  output logic        done,
  output logic [15:0] Product
);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] m;
  logic [7:0] p_hi;
  logic [7:0] p_lo;
  logic [2:0] cnt;
  logic       load;
  logic       step;
  logic [7:0] add_b;
  logic [7:0] sum;
  logic       cout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // IDLE and the unused encoding share the default branch.
  always_comb begin
    state_nxt = ST_IDLE;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      ST_RUN: begin
        step      = 1'b1;
        state_nxt = (cnt == CNT_LAST) ? ST_DONE : ST_RUN;
      end
      default: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = ST_RUN;
        end
      end
    endcase
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  assign add_b = p_lo[0] ? m : 8'h00;

  adder_8bit u_adder (
    .A    (p_hi),
    .B    (add_b),
    .Cin  (1'b0),
    .Sum  (sum),
    .Cout (cout)
  );

  // The 9-bit {cout,sum} shifts right into the product register, so no carry is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m    <= 8'h00;
      p_hi <= 8'h00;
      p_lo <= 8'h00;
      cnt  <= 3'd0;
    end else if (load) begin
      m    <= A;
      p_hi <= 8'h00;
      p_lo <= B;
      cnt  <= 3'd0;
    end else if (step) begin
      {p_hi, p_lo} <= {cout, sum, p_lo[7:1]};
      cnt          <= cnt + 3'd1;
    end
  end

  assign Product = {p_hi, p_lo};

endmodule
